// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin sharing of one BRAM port among NUM_MST requesters
// Winning command is registered onto the BRAM port; a read-ID pipeline routes each read response back to its issuer.
module bram_port_arbiter #(
   parameter int NUM_MST    = 2,
   parameter int ADDR_BITW  = 32,
   parameter int DATA_BITW  = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                             Clk_CI,
   input  logic                             Rst_RI,
   input  logic [NUM_MST-1:0]               Req_SI,
   output logic [NUM_MST-1:0]               Gnt_SO,
   input  logic [NUM_MST*ADDR_BITW-1:0]     Addr_DI,
   input  logic [NUM_MST*DATA_BITW-1:0]     WrData_DI,
   input  logic [NUM_MST*DATA_BITW/8-1:0]   WrEn_SI,
   output logic [NUM_MST-1:0]               RdValid_SO,
   output logic [DATA_BITW-1:0]             RdData_DO,
   output logic                             BramEn_SO,
   output logic [ADDR_BITW-1:0]             BramAddr_DO,
   output logic [DATA_BITW-1:0]             BramWrData_DO,
   output logic [DATA_BITW/8-1:0]           BramWrEn_SO,
   input  logic [DATA_BITW-1:0]             BramRdData_DI
);
   localparam int IDXW = $clog2(NUM_MST);
   localparam int BEW  = DATA_BITW / 8;

   logic [IDXW-1:0]      ptr;
   logic [IDXW-1:0]      ptr_next;
   logic [IDXW-1:0]      win;
   logic                 found;
   logic                 xfer;
   logic [ADDR_BITW-1:0] sel_addr;
   logic [DATA_BITW-1:0] sel_wdata;
   logic [BEW-1:0]       sel_wren;
   logic [RD_LATENCY:0]  rd_vld;
   logic [IDXW-1:0]      rd_id [RD_LATENCY+1];

   // Two passes give the wrap-around search: indices at/after the pointer first, then the ones before it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (!found && Req_SI[i] && i >= int'(ptr)) begin
            found = 1'b1;
            win   = IDXW'(i);
         end
      end
      for (int i = 0; i < NUM_MST; i++) begin
         if (!found && Req_SI[i] && i < int'(ptr)) begin
            found = 1'b1;
            win   = IDXW'(i);
         end
      end
   end

   assign xfer     = found && !Rst_RI;
   assign ptr_next = (win == IDXW'(NUM_MST-1)) ? '0 : win + 1'b1;

   always_comb begin
      Gnt_SO = '0;
      if (xfer) Gnt_SO[win] = 1'b1;
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wren  = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (int'(win) == i) begin
            sel_addr  = Addr_DI[i*ADDR_BITW +: ADDR_BITW];
            sel_wdata = WrData_DI[i*DATA_BITW +: DATA_BITW];
            sel_wren  = WrEn_SI[i*BEW +: BEW];
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         ptr           <= '0;
         BramEn_SO     <= 1'b0;
         BramAddr_DO   <= '0;
         BramWrData_DO <= '0;
         BramWrEn_SO   <= '0;
         rd_vld        <= '0;
         for (int k = 0; k <= RD_LATENCY; k++) rd_id[k] <= '0;
      end else begin
         BramEn_SO <= xfer;
         if (xfer) begin
            ptr           <= ptr_next;
            BramAddr_DO   <= sel_addr;
            BramWrData_DO <= sel_wdata;
            BramWrEn_SO   <= sel_wren;
         end else begin
            BramWrEn_SO   <= '0;
         end
         // Stage 0 lines up with the BramEn cycle; stage RD_LATENCY lines up with the returned data.
         rd_vld   <= {rd_vld[RD_LATENCY-1:0], xfer && (sel_wren == '0)};
         rd_id[0] <= win;
         for (int k = 1; k <= RD_LATENCY; k++) rd_id[k] <= rd_id[k-1];
      end
   end

   always_comb begin
      RdValid_SO = '0;
      if (rd_vld[RD_LATENCY]) RdValid_SO[rd_id[RD_LATENCY]] = 1'b1;
   end

   assign RdData_DO = BramRdData_DI;

endmodule
